// File: rtl/vending_controller_pkg.sv
// Shared types, coin table and default pricing for the vending controller.
package vending_controller_pkg;

   localparam int unsigned MONEY_W = 8;
   localparam int unsigned CODE_W  = 2;
   localparam int unsigned TIMER_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      VEND    = 2'd2,
      REFUND  = 2'd3
   } state_t;

   localparam logic [MONEY_W-1:0] DEF_PRICE_0    = 8'd15;
   localparam logic [MONEY_W-1:0] DEF_PRICE_1    = 8'd20;
   localparam logic [MONEY_W-1:0] DEF_PRICE_2    = 8'd25;
   localparam logic [MONEY_W-1:0] DEF_PRICE_3    = 8'd40;
   localparam logic [MONEY_W-1:0] DEF_MAX_CREDIT = 8'd200;
   localparam logic [TIMER_W-1:0] DEF_TIMEOUT    = 16'd1000;

   // Registered controller outputs, updated as one record each cycle
   typedef struct packed {
      logic               end_trans;
      logic               refund_valid;
      logic               coin_reject;
      logic               insufficient;
      logic               busy;
      logic [MONEY_W-1:0] sum_money;
      logic [MONEY_W-1:0] price;
      logic [CODE_W-1:0]  item_select;
      logic [MONEY_W-1:0] refund_amount;
   } ctrl_regs_t;

   function automatic logic [MONEY_W-1:0] coin_value(input logic [CODE_W-1:0] code);
      case (code)
         2'b00:   coin_value = 8'd5;
         2'b01:   coin_value = 8'd10;
         2'b10:   coin_value = 8'd20;
         default: coin_value = 8'd50;
      endcase
   endfunction

endpackage

// File: rtl/vending_controller_credit_timer.sv
// Idle timeout counter; saturates at TIMEOUT_CYC-1 and flags expiry there.
module credit_timer
   import vending_controller_pkg::*;
#(
   parameter logic [TIMER_W-1:0] TIMEOUT_CYC = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic expired
);

   localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT_CYC - 16'd1);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count != LIMIT) begin
         count <= count + 16'd1;
      end
   end

   assign expired = (count == LIMIT);

endmodule

// File: rtl/vending_controller.sv
// Coin-operated vending controller: credit accumulation, item select, vend and refund.
module vending_controller
   import vending_controller_pkg::*;
#(
   parameter logic [MONEY_W-1:0] PRICE_0     = DEF_PRICE_0,
   parameter logic [MONEY_W-1:0] PRICE_1     = DEF_PRICE_1,
   parameter logic [MONEY_W-1:0] PRICE_2     = DEF_PRICE_2,
   parameter logic [MONEY_W-1:0] PRICE_3     = DEF_PRICE_3,
   parameter logic [MONEY_W-1:0] MAX_CREDIT  = DEF_MAX_CREDIT,
   parameter logic [TIMER_W-1:0] TIMEOUT_CYC = DEF_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               coin_valid,
   input  logic [CODE_W-1:0]  coin_code,
   input  logic               sel_valid,
   input  logic [CODE_W-1:0]  sel_item,
   input  logic               cancel,
   output logic               end_trans,
   output logic [MONEY_W-1:0] sum_money,
   output logic [MONEY_W-1:0] price,
   output logic [CODE_W-1:0]  item_select,
   output logic               refund_valid,
   output logic [MONEY_W-1:0] refund_amount,
   output logic               coin_reject,
   output logic               insufficient,
   output logic               busy
);

   state_t             state, state_nxt;
   ctrl_regs_t         regs, regs_nxt;
   logic               timer_clear;
   logic               expired;
   logic [MONEY_W:0]   credit_sum;
   logic               coin_fits;
   logic [MONEY_W-1:0] sel_price;

   credit_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_credit_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (timer_clear),
      .expired (expired)
   );

   // Extra carry bit lets the ceiling check see a sum that would overflow 8 bits
   always_comb begin
      credit_sum = {1'b0, regs.sum_money} + {1'b0, coin_value(coin_code)};
      coin_fits  = (credit_sum <= {1'b0, MAX_CREDIT});
      case (sel_item)
         2'd0:    sel_price = PRICE_0;
         2'd1:    sel_price = PRICE_1;
         2'd2:    sel_price = PRICE_2;
         default: sel_price = PRICE_3;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         regs  <= '0;
      end else begin
         state <= state_nxt;
         regs  <= regs_nxt;
      end
   end

   always_comb begin
      state_nxt             = state;
      regs_nxt              = regs;
      regs_nxt.end_trans    = 1'b0;
      regs_nxt.refund_valid = 1'b0;
      regs_nxt.coin_reject  = 1'b0;
      regs_nxt.insufficient = 1'b0;
      timer_clear           = 1'b1;

      case (state)
         IDLE: begin
            if (coin_valid) begin
               if (coin_fits) begin
                  regs_nxt.sum_money = credit_sum[MONEY_W-1:0];
                  state_nxt          = COLLECT;
               end else begin
                  regs_nxt.coin_reject = 1'b1;
               end
            end
         end
         COLLECT: begin
            timer_clear = 1'b0;
            // Priority: cancel > select > coin > timeout; a losing coin is returned
            if (cancel) begin
               state_nxt              = REFUND;
               regs_nxt.refund_valid  = 1'b1;
               regs_nxt.refund_amount = regs.sum_money;
               regs_nxt.coin_reject   = coin_valid;
            end else if (sel_valid) begin
               regs_nxt.item_select = sel_item;
               regs_nxt.price       = sel_price;
               regs_nxt.coin_reject = coin_valid;
               if (regs.sum_money >= sel_price) begin
                  state_nxt          = VEND;
                  regs_nxt.end_trans = 1'b1;
               end else begin
                  regs_nxt.insufficient = 1'b1;
               end
            end else if (coin_valid) begin
               timer_clear = 1'b1;
               if (coin_fits) begin
                  regs_nxt.sum_money = credit_sum[MONEY_W-1:0];
               end else begin
                  regs_nxt.coin_reject = 1'b1;
               end
            end else if (expired) begin
               state_nxt              = REFUND;
               regs_nxt.refund_valid  = 1'b1;
               regs_nxt.refund_amount = regs.sum_money;
            end
         end
         VEND: begin
            state_nxt            = IDLE;
            regs_nxt.sum_money   = '0;
            regs_nxt.price       = '0;
            regs_nxt.coin_reject = coin_valid;
         end
         REFUND: begin
            state_nxt            = IDLE;
            regs_nxt.sum_money   = '0;
            regs_nxt.coin_reject = coin_valid;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      regs_nxt.busy = (state_nxt != IDLE);
   end

   assign end_trans     = regs.end_trans;
   assign sum_money     = regs.sum_money;
   assign price         = regs.price;
   assign item_select   = regs.item_select;
   assign refund_valid  = regs.refund_valid;
   assign refund_amount = regs.refund_amount;
   assign coin_reject   = regs.coin_reject;
   assign insufficient  = regs.insufficient;
   assign busy          = regs.busy;

endmodule

// File: doc/vending_controller.md
VENDING_CONTROLLER -- requirements
Module: vending_controller

Interface
REQ-001 SHALL have parameters: PRICE_0 (default 8'd15), the item 0 price; PRICE_1 (8'd20), the item 1 price; PRICE_2 (8'd25), the item 2 price; PRICE_3 (8'd40), the item 3 price; MAX_CREDIT (8'd200), the credit ceiling; TIMEOUT_CYC (16'd1000), the idle-refund delay in cycles.
REQ-002 SHALL have ports, one clock and asynchronous active-low reset:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- coin_valid  in  1  one-cycle coin-inserted strobe
- coin_code  in  2  coin value: 00=5, 01=10, 10=20, 11=50
- sel_valid  in  1  one-cycle item-select strobe
- sel_item  in  2  selected item index
- cancel  in  1  one-cycle cancel strobe
- end_trans  out  1  one-cycle vend strobe to the output datapath
- sum_money  out  8  accumulated credit
- price  out  8  price of the latched item
- item_select  out  2  latched item index
- refund_valid  out  1  one-cycle refund strobe
- refund_amount  out  8  credit returned; valid with refund_valid
- coin_reject  out  1  one-cycle coin-returned strobe
- insufficient  out  1  one-cycle credit-too-low strobe
- busy  out  1  high in any state other than IDLE

Function
REQ-003 SHALL implement states IDLE, COLLECT, VEND, REFUND, encoded 2 bits.
REQ-004 IDLE: coin_valid SHALL add the coin value to sum_money and go to COLLECT next cycle; sel_valid and cancel SHALL be ignored.
REQ-005 COLLECT: coin_valid SHALL add the coin value and restart the timeout counter.
REQ-006 A coin that would make sum_money exceed MAX_CREDIT SHALL not be added; coin_reject SHALL pulse for 1 cycle, in any state.
REQ-007 COLLECT sel_valid SHALL latch sel_item into item_select and the matching PRICE_n into price in the same edge.
REQ-008 If sum_money >= that price: go to VEND. Otherwise: pulse insufficient for 1 cycle and stay in COLLECT, keeping the latched item.
REQ-009 VEND SHALL last exactly 1 cycle with end_trans=1; sum_money, price and item_select SHALL stay stable during it.
REQ-010 Latency SHALL be 1 cycle: sel_valid sampled at edge N puts end_trans high for the cycle following edge N.
REQ-011 After VEND: return to IDLE; sum_money and price cleared to 0; item_select held.
REQ-012 COLLECT cancel, or the timeout counter reaching TIMEOUT_CYC-1 with no coin, SHALL go to REFUND.
REQ-013 REFUND SHALL last 1 cycle: refund_valid=1, refund_amount=sum_money, end_trans=0. It then goes to IDLE with sum_money=0.
REQ-014 Same-cycle priority in COLLECT SHALL be cancel > sel_valid > coin_valid > timeout. A coin losing to cancel or sel_valid SHALL be rejected via coin_reject.
REQ-015 coin_valid during VEND or REFUND SHALL be rejected with coin_reject; sel_valid and cancel there SHALL be ignored.
REQ-016 The 8-bit addition SHALL be checked against MAX_CREDIT using a 9-bit intermediate; sum_money SHALL never wrap.
REQ-017 The timeout counter SHALL be 16 bits, cleared in IDLE, VEND and REFUND, and saturate at TIMEOUT_CYC-1.

Reset
REQ-018 rst_n low SHALL asynchronously force IDLE, with sum_money=0, price=0, item_select=0, timer=0, and all strobes and busy at 0.
REQ-019 Reset mid-transaction SHALL discard credit, with no refund_valid or end_trans pulse; operation SHALL resume on the first edge after rst_n rises.

Structure
REQ-020 A shared package SHALL hold the state encoding, the coin-code-to-value table (5/10/20/50) and the default prices.
REQ-021 The block SHALL contain one sub-module, credit_timer, holding the timeout counter and its expire flag; the FSM and credit register stay in the top level.
REQ-022 All outputs SHALL be registered; there SHALL be no combinational input-to-output path.

Verification
REQ-023 Reset, then coins 10, 10 (code 01 twice), then sel_item=1 -> end_trans 1 cycle after select; sum_money=20, price=20, item_select=1; then sum_money=0 and busy=0.
REQ-024 Coin 5, then sel_item=3 -> insufficient pulse and state stays COLLECT; then coins 50, 50 and select 3 -> end_trans with sum_money=105, price=40.
REQ-025 Coins 50 x4 (sum 200), then a 5 -> coin_reject pulse, sum_money stays 200; then cancel -> refund_valid with refund_amount=200, no end_trans.
REQ-026 Coin 20, then idle TIMEOUT_CYC cycles -> refund_valid with refund_amount=20, then IDLE.
REQ-027 cancel, sel_valid and coin_valid in the same cycle in COLLECT -> REFUND, coin_reject=1, end_trans=0.
REQ-028 rst_n asserted mid-COLLECT with sum 30 -> immediately sum_money=0 and busy=0; no refund_valid is ever seen.
